// File: rtl/dfi_init_ctrl.sv
// dfi_init_ctrl: controller-side DFI init handshake initiator.
// Raises dfi_init_start on request, waits for dfi_init_done to rise and then
// fall (4-phase), with a per-phase timeout, and reports sticky status.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i                 start-init request (accepted in IDLE/FAIL only)
//   clr_i                 clear sticky status flags
//   dfi_init_done_i       init done from PHY/GPIO side (asynchronous)
//   dfi_init_start_o      init start to PHY/GPIO side
//   busy_o                handshake in progress
//   init_ok_o             sticky: last handshake completed
//   timeout_o             sticky: last handshake timed out
//   stale_o               sticky: done already high at request
//   done_pulse_o          one-cycle pulse when a handshake ends
module dfi_init_ctrl #(
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic clr_i,
    input  logic dfi_init_done_i,
    output logic dfi_init_start_o,
    output logic busy_o,
    output logic init_ok_o,
    output logic timeout_o,
    output logic stale_o,
    output logic done_pulse_o
);

    localparam int unsigned CntWRaw = $clog2(TimeoutCycles + 1);
    localparam int unsigned CntW    = (CntWRaw < 1) ? 1 : CntWRaw;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_FAIL    = 2'd3
    } state_t;

    logic done_s;

    // Synchronizer on the incoming done; zero stages uses the input directly.
    generate
        if (SyncStages == 0) begin : g_nosync
            assign done_s = dfi_init_done_i;
        end else begin : g_sync
            logic [SyncStages-1:0] sync_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= dfi_init_done_i;
                    for (int i = 1; i < int'(SyncStages); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign done_s = sync_q[SyncStages-1];
        end
    endgenerate

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            timeout_hit;
    logic            start_d, busy_d, ok_d, to_d, stale_d, pulse_d;

    // Saturating phase counter and timeout compare (disabled when TimeoutCycles is 0).
    assign cnt_inc     = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));

    // Next-state, counter, flag and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ok_d    = init_ok_o;
        to_d    = timeout_o;
        stale_d = stale_o;
        pulse_d = 1'b0;

        // Clear first so any flag set below takes priority.
        if (clr_i) begin
            ok_d    = 1'b0;
            to_d    = 1'b0;
            stale_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_FAIL: begin
                cnt_d = '0;
                if (req_i) begin
                    if (done_s) begin
                        state_d = ST_FAIL;
                        stale_d = 1'b1;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        ok_d    = 1'b0;
                        to_d    = 1'b0;
                        stale_d = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (done_s) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d = ST_FAIL;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                if (!done_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ok_d    = 1'b1;
                    pulse_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ST_FAIL;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        start_d = (state_d == ST_REQ);
        busy_d  = (state_d == ST_REQ) || (state_d == ST_RELEASE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            dfi_init_start_o <= 1'b0;
            busy_o           <= 1'b0;
            init_ok_o        <= 1'b0;
            timeout_o        <= 1'b0;
            stale_o          <= 1'b0;
            done_pulse_o     <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            dfi_init_start_o <= start_d;
            busy_o           <= busy_d;
            init_ok_o        <= ok_d;
            timeout_o        <= to_d;
            stale_o          <= stale_d;
            done_pulse_o     <= pulse_d;
        end
    end

endmodule

// File: tb/tb_dfi_init_ctrl.sv
// Directed bench for dfi_init_ctrl with SyncStages=2, TimeoutCycles=16.
module tb_dfi_init_ctrl;

    logic clk_i = 1'b0;
    logic rst_i;
    logic req_i;
    logic clr_i;
    logic dfi_init_done_i;
    logic dfi_init_start_o;
    logic busy_o;
    logic init_ok_o;
    logic timeout_o;
    logic stale_o;
    logic done_pulse_o;

    int n_cmp  = 0;
    int n_fail = 0;

    dfi_init_ctrl #(
        .SyncStages    (2),
        .TimeoutCycles (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .clr_i            (clr_i),
        .dfi_init_done_i  (dfi_init_done_i),
        .dfi_init_start_o (dfi_init_start_o),
        .busy_o           (busy_o),
        .init_ok_o        (init_ok_o),
        .timeout_o        (timeout_o),
        .stale_o          (stale_o),
        .done_pulse_o     (done_pulse_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hi;
        int t;
        rst_i = 1'b1; req_i = 1'b0; clr_i = 1'b0; dfi_init_done_i = 1'b0;

        // Reset
        cyc(); cyc();
        check("rst_start", 32'(dfi_init_start_o), 0);
        check("rst_busy",  32'(busy_o), 0);
        check("rst_flags", 32'({init_ok_o, timeout_o, stale_o, done_pulse_o}), 0);
        rst_i = 1'b0;
        cyc();

        // Nominal handshake
        req_i = 1'b1;
        cyc();
        check("nom_start_rise", 32'(dfi_init_start_o), 1);
        check("nom_busy_rise",  32'(busy_o), 1);
        req_i = 1'b0;
        hi = 1;
        repeat (5) begin cyc(); if (dfi_init_start_o) hi++; end
        dfi_init_done_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!dfi_init_start_o) break;
            hi++;
        end
        check("nom_start_width", 32'(hi), 8);
        check("nom_busy_release", 32'(busy_o), 1);
        repeat (5) cyc();
        dfi_init_done_i = 1'b0;
        cyc();
        check("nom_busy_n0", 32'(busy_o), 1);
        cyc();
        check("nom_pulse_early", 32'(done_pulse_o), 0);
        cyc();
        check("nom_busy_done", 32'(busy_o), 0);
        check("nom_ok",        32'(init_ok_o), 1);
        check("nom_pulse",     32'(done_pulse_o), 1);
        check("nom_timeout",   32'(timeout_o), 0);
        cyc();
        check("nom_pulse_one", 32'(done_pulse_o), 0);
        check("nom_ok_sticky", 32'(init_ok_o), 1);

        // REQ-phase timeout
        req_i = 1'b1;
        cyc();
        check("reqto_start", 32'(dfi_init_start_o), 1);
        check("reqto_ok_clr", 32'(init_ok_o), 0);
        req_i = 1'b0;
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!dfi_init_start_o) break;
            hi++;
        end
        check("reqto_width",   32'(hi), 16);
        check("reqto_timeout", 32'(timeout_o), 1);
        check("reqto_busy",    32'(busy_o), 0);
        check("reqto_pulse",   32'(done_pulse_o), 1);
        cyc();
        check("reqto_pulse_one", 32'(done_pulse_o), 0);

        // RELEASE-phase timeout
        req_i = 1'b1;
        cyc();
        check("relto_to_clr", 32'(timeout_o), 0);
        req_i = 1'b0;
        dfi_init_done_i = 1'b1;
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!dfi_init_start_o) break;
            hi++;
        end
        check("relto_start_width", 32'(hi), 3);
        t = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            t++;
            if (timeout_o) break;
        end
        check("relto_cycles", 32'(t), 16);
        check("relto_ok",     32'(init_ok_o), 0);
        check("relto_busy",   32'(busy_o), 0);
        check("relto_pulse",  32'(done_pulse_o), 1);

        // Stale done
        hi = 0;
        repeat (4) begin cyc(); if (dfi_init_start_o) hi++; end
        req_i = 1'b1;
        cyc();
        if (dfi_init_start_o) hi++;
        check("stale_flag",  32'(stale_o), 1);
        check("stale_pulse", 32'(done_pulse_o), 1);
        check("stale_busy",  32'(busy_o), 0);
        req_i = 1'b0;
        cyc();
        if (dfi_init_start_o) hi++;
        check("stale_no_start", 32'(hi), 0);
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        check("stale_clr", 32'({init_ok_o, timeout_o, stale_o}), 0);

        // Clear+request priority in FAIL, ignored request during REQ
        req_i = 1'b1;
        cyc();
        req_i = 1'b0;
        check("prio_stale_set", 32'(stale_o), 1);
        dfi_init_done_i = 1'b0;
        repeat (3) cyc();
        clr_i = 1'b1; req_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        check("prio_start", 32'(dfi_init_start_o), 1);
        check("prio_flags", 32'({init_ok_o, timeout_o, stale_o}), 0);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            if (hi == 6) req_i = 1'b0;
            cyc();
            if (!dfi_init_start_o) break;
            hi++;
        end
        req_i = 1'b0;
        check("ign_width",   32'(hi), 16);
        check("ign_timeout", 32'(timeout_o), 1);

        // Reset in mid-handshake, then a clean minimum-latency handshake
        req_i = 1'b1;
        cyc();
        req_i = 1'b0;
        repeat (3) cyc();
        check("mid_start_pre", 32'(dfi_init_start_o), 1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        check("mid_rst_outs", 32'({dfi_init_start_o, busy_o, init_ok_o, timeout_o, stale_o, done_pulse_o}), 0);
        req_i = 1'b1;
        cyc();
        req_i = 1'b0;
        dfi_init_done_i = 1'b1;
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!dfi_init_start_o) break;
            hi++;
        end
        check("post_start_width", 32'(hi), 3);
        dfi_init_done_i = 1'b0;
        t = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            t++;
            if (done_pulse_o) break;
        end
        check("post_complete_cycles", 32'(t), 3);
        check("post_ok",   32'(init_ok_o), 1);
        check("post_busy", 32'(busy_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dfi_init_ctrl.md
# dfi_init_ctrl

Controller-side DFI initialization handshake initiator. On a request from the memory-controller sequencer, it drives `dfi_init_start` and waits for the PHY-side `dfi_init_done` using a 4-phase handshake, with per-phase timeout. It then reports success, timeout or stale-done status. It sits on the opposite end of the init-start/init-done GPIO pair exposed by the DFI GPIO CSR block.

## Interface

Parameters:
- `SyncStages`, default 2: number of flops on `dfi_init_done_i` before use. 0 means direct use.
- `TimeoutCycles`, default 1024: per-phase timeout in clk cycles. 0 disables the timeout.

Ports:
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `req_i` input 1: start-init request. Level sampled; accepted only in IDLE or FAIL.
- `clr_i` input 1: clear sticky status flags.
- `dfi_init_done_i` input 1: init done from the PHY/GPIO side.
- `dfi_init_start_o` output 1: init start to the PHY/GPIO side. Registered.
- `busy_o` output 1: handshake in progress.
- `init_ok_o` output 1: sticky, last handshake completed.
- `timeout_o` output 1: sticky, last handshake timed out.
- `stale_o` output 1: sticky, done was already high when the request arrived.
- `done_pulse_o` output 1: one-cycle pulse when the handshake ends for any reason.

## Operation

- `done_s` is `dfi_init_done_i` after `SyncStages` flops. The sync flops reset to 0.
- FSM states are IDLE, REQ, RELEASE and FAIL. All outputs are registered from state and flags.
- **IDLE** (`start`=0, `busy`=0):
  - If `req_i`=1 and `done_s`=1: go to FAIL, set `stale_o`, pulse `done_pulse_o`.
  - If `req_i`=1 and `done_s`=0: go to REQ. Clear all sticky flags and the phase counter.
- **REQ** (`start`=1, `busy`=1):
  - If `done_s`=1: go to RELEASE and reset the counter.
  - Else if counter = `TimeoutCycles`-1 and `TimeoutCycles`≠0: go to FAIL and set `timeout_o`.
- **RELEASE** (`start`=0, `busy`=1):
  - If `done_s`=0: go to IDLE, set `init_ok_o`, pulse `done_pulse_o`.
  - Else on timeout (same rule as REQ): go to FAIL and set `timeout_o`.
- **FAIL** (`start`=0, `busy`=0): behaves as IDLE for `req_i` and `clr_i`. Kept as a separate state for observability.
- Phase counter:
  - Width is `$clog2(TimeoutCycles+1)`, minimum 1.
  - Increments every cycle in REQ/RELEASE and saturates.
  - Resets to 0 on every phase entry.
- `clr_i` clears `init_ok_o`, `timeout_o` and `stale_o`. It has no effect on the FSM or on `dfi_init_start_o`.
  - `clr_i` and an accepted `req_i` in the same cycle: the request wins; flags are cleared and REQ is entered.
  - `clr_i` and a flag-setting transition in the same cycle: the set wins.
- `req_i` while `busy_o`=1 is ignored, with no queuing.
- Done toggling back to 0 during REQ before it was ever seen high has no effect; the FSM still waits for `done_s`=1.

## Timing

- Reset: at the first rising edge with `rst_i`=1, the FSM goes to IDLE and every output is 0, including the sync flops and counter. Reset in mid-handshake drops `dfi_init_start_o` at that edge.
- Request to start: `req_i` high at edge k (IDLE, `done_s`=0) gives `dfi_init_start_o`=1 and `busy_o`=1 after edge k.
- Done to start release:
  - `dfi_init_done_i` rises before edge m; `done_s` is high after edge m+`SyncStages`-1.
  - `dfi_init_start_o` falls after edge m+`SyncStages`. With `SyncStages`=0 it falls after edge m.
- Completion: `dfi_init_done_i` falls before edge n. After edge n+`SyncStages`:
  - `busy_o`=0, `init_ok_o`=1, `done_pulse_o`=1 for exactly one cycle.
- Timeout: if done never arrives, `dfi_init_start_o` stays high for exactly `TimeoutCycles` cycles. It then goes low, `timeout_o`=1 and `done_pulse_o` pulses in the same cycle.
- Minimum request-to-completion time is 2·(`SyncStages`+1) cycles.
- A new request is accepted the cycle after `busy_o` falls.

## Test plan

- **Nominal** (`SyncStages`=2, `TimeoutCycles`=16):
  - Stimulus: pulse `req_i`; raise done 5 cycles after start; drop done 5 cycles after start falls.
  - Required: start high for 5+3 cycles; `init_ok_o`=1; one `done_pulse_o`; `timeout_o`=0.
- **REQ timeout** (`TimeoutCycles`=16):
  - Stimulus: `req_i`, done held 0.
  - Required: start high exactly 16 cycles; then `timeout_o`=1, `busy_o`=0, one pulse.
- **RELEASE timeout**:
  - Stimulus: done rises and never falls.
  - Required: `timeout_o`=1 16 cycles after start falls; `init_ok_o`=0.
- **Stale done**:
  - Stimulus: `done_i`=1 for 4 cycles, then `req_i`.
  - Required: start never asserts; `stale_o`=1; FAIL state. A following `clr_i` gives all flags 0.
- **Ignored request and priority**:
  - Stimulus: `req_i` during REQ is ignored, so start timing is unchanged. `clr_i`+`req_i` in FAIL.
  - Required: REQ entered; flags 0 next cycle.
- **Reset mid-handshake**:
  - Stimulus: assert `rst_i` for 1 cycle while in REQ.
  - Required: all outputs 0 after that edge; the next `req_i` gives a normal handshake.
